// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock show-ahead FIFO.
// Optional occupancy output is enabled by defining SYNC_FIFO_COUNT_EN.
package sync_fifo_pkg;

  localparam int DefWordLength = 8;
  localparam int DefAddrBits   = 4;

  typedef logic [DefAddrBits-1:0] ptr_t;
  typedef logic [DefAddrBits:0]   cnt_t;

  typedef enum logic [1:0] {
    OpIdle,
    OpWr,
    OpRd,
    OpBoth
  } fifo_op_e;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the FIFO; count_o exists only when
// SYNC_FIFO_COUNT_EN is defined.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WordLength = DefWordLength,
  parameter int AddrBits   = DefAddrBits
) ();

  logic                  rd_i;
  logic                  wr_i;
  logic [WordLength-1:0] w_data_i;
  logic [WordLength-1:0] r_data_o;
  logic                  empty_o;
  logic                  full_o;
`ifdef SYNC_FIFO_COUNT_EN
  logic [AddrBits:0]     count_o;
`endif

  modport master (
    output rd_i,
    output wr_i,
    output w_data_i,
    input  r_data_o,
    input  empty_o,
`ifdef SYNC_FIFO_COUNT_EN
    input  count_o,
`endif
    input  full_o
  );

  modport slave (
    input  rd_i,
    input  wr_i,
    input  w_data_i,
    output r_data_o,
    output empty_o,
`ifdef SYNC_FIFO_COUNT_EN
    output count_o,
`endif
    output full_o
  );

endinterface

// File: rtl/sync_fifo_regfile.sv
// FIFO storage: synchronous write, asynchronous read, never cleared.
module sync_fifo_regfile
  import sync_fifo_pkg::*;
#(
  parameter int WordLength = DefWordLength,
  parameter int AddrBits   = DefAddrBits
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AddrBits-1:0]   waddr,
  input  logic [WordLength-1:0] wdata,
  input  logic [AddrBits-1:0]   raddr,
  output logic [WordLength-1:0] rdata
);

  localparam int Depth = fifo_depth(AddrBits);

  logic [WordLength-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Define SYNC_FIFO_COUNT_EN to add the registered count_o output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WordLength = DefWordLength,
  parameter int AddrBits   = DefAddrBits
) (
  input  logic       clk_i,
  input  logic       rst_i,
  sync_fifo_if.slave bus
);

  logic [AddrBits-1:0]   wr_ptr;
  logic [AddrBits-1:0]   rd_ptr;
  logic [AddrBits-1:0]   wr_nxt;
  logic [AddrBits-1:0]   rd_nxt;
  logic                  empty_q;
  logic                  full_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [WordLength-1:0] rdata;
  fifo_op_e              op;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign wr_acc = bus.wr_i & (~full_q | bus.rd_i);
  assign rd_acc = bus.rd_i & ~empty_q;
  assign wr_nxt = wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr + 1'b1;

  always_comb begin
    op = OpIdle;
    unique case (1'b1)
      (wr_acc & rd_acc):  op = OpBoth;
      (wr_acc & ~rd_acc): op = OpWr;
      (rd_acc & ~wr_acc): op = OpRd;
      default:            op = OpIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_nxt;
      end
      if (rd_acc) begin
        rd_ptr <= rd_nxt;
      end
      unique case (op)
        OpWr: begin
          empty_q <= 1'b0;
          full_q  <= (wr_nxt == rd_ptr);
        end
        OpRd: begin
          full_q  <= 1'b0;
          empty_q <= (rd_nxt == wr_ptr);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SYNC_FIFO_COUNT_EN
  logic [AddrBits:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else begin
      unique case (op)
        OpWr:    cnt <= cnt + 1'b1;
        OpRd:    cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.count_o = cnt;
`endif

  sync_fifo_regfile #(
    .WordLength (WordLength),
    .AddrBits   (AddrBits)
  ) u_regfile (
    .clk   (clk_i),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.w_data_i),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.r_data_o = rdata;
  assign bus.empty_o  = empty_q;
  assign bus.full_o   = full_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WordLength=8, AddrBits=4).
module tb_sync_fifo;

  localparam int W = 8;
  localparam int A = 4;
  localparam int D = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_if #(.WordLength(W), .AddrBits(A)) bus ();

  sync_fifo #(
    .WordLength (W),
    .AddrBits   (A)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [W-1:0] d);
    bus.rd_i     = rd;
    bus.wr_i     = wr;
    bus.w_data_i = d;
    step();
    bus.rd_i = 1'b0;
    bus.wr_i = 1'b0;
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef SYNC_FIFO_COUNT_EN
    check(tag, 32'(bus.count_o), exp);
`else
    if (exp < 0) $display("bad count %0d", exp);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic fill16();
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, W'(i));
  endtask

  logic [W-1:0] q[$];
  logic         rd;
  logic         wr;
  logic [W-1:0] d;
  bit           wacc;
  bit           racc;

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.rd_i     = 1'b0;
    bus.wr_i     = 1'b0;
    bus.w_data_i = '0;
    #2;

    // 1 reset
    do_reset();
    check("rst_empty", 32'(bus.empty_o), 1);
    check("rst_full", 32'(bus.full_o), 0);
    check_cnt("rst_count", 0);

    // 2 fill
    for (int i = 0; i < D - 1; i++) drive(1'b0, 1'b1, W'(i));
    check("fill15_full", 32'(bus.full_o), 0);
    drive(1'b0, 1'b1, 8'h0F);
    check("fill_full", 32'(bus.full_o), 1);
    check("fill_empty", 32'(bus.empty_o), 0);
    check_cnt("fill_count", 16);
    drive(1'b0, 1'b1, 8'hAA);
    check("ovf_full", 32'(bus.full_o), 1);
    check("ovf_head", 32'(bus.r_data_o), 32'h00);
    check_cnt("ovf_count", 16);

    // 3 drain
    for (int i = 0; i < D; i++) begin
      check($sformatf("drain%0d", i), 32'(bus.r_data_o), i);
      drive(1'b1, 1'b0, 8'h00);
    end
    check("drain_empty", 32'(bus.empty_o), 1);
    check("drain_full", 32'(bus.full_o), 0);
    drive(1'b1, 1'b0, 8'h00);
    check("udf_empty", 32'(bus.empty_o), 1);
    check_cnt("udf_count", 0);
    drive(1'b0, 1'b1, 8'h77);
    check("udf_head", 32'(bus.r_data_o), 32'h77);
    drive(1'b1, 1'b0, 8'h00);
    check("udf_empty2", 32'(bus.empty_o), 1);

    // 4 rd+wr while empty
    drive(1'b1, 1'b1, 8'h5A);
    check("erw_empty", 32'(bus.empty_o), 0);
    check("erw_head", 32'(bus.r_data_o), 32'h5A);
    check_cnt("erw_count", 1);
    drive(1'b1, 1'b0, 8'h00);
    check("erw_drain", 32'(bus.empty_o), 1);

    // 5 rd+wr while full
    fill16();
    drive(1'b1, 1'b1, 8'hC3);
    check("frw_full", 32'(bus.full_o), 1);
    check_cnt("frw_count", 16);
    for (int i = 0; i < D; i++) begin
      check($sformatf("frw_drain%0d", i), 32'(bus.r_data_o),
            (i == D - 1) ? 32'hC3 : i + 1);
      drive(1'b1, 1'b0, 8'h00);
    end
    check("frw_empty", 32'(bus.empty_o), 1);

    // 6 interleaved ops against a queue model, write-heavy then read-heavy
    for (int i = 0; i < 40; i++) begin
      wr   = (i < 24) ? 1'b1 : (i % 3 == 0);
      rd   = (i < 24) ? (i % 3 == 2) : 1'b1;
      d    = W'(i * 7 + 3);
      wacc = wr && (q.size() < D || rd);
      racc = rd && q.size() > 0;
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      drive(rd, wr, d);
      check($sformatf("mdl_empty%0d", i), 32'(bus.empty_o),
            32'(q.size() == 0));
      check($sformatf("mdl_full%0d", i), 32'(bus.full_o),
            32'(q.size() == D));
      check_cnt($sformatf("mdl_count%0d", i), q.size());
      if (q.size() > 0)
        check($sformatf("mdl_head%0d", i), 32'(bus.r_data_o), 32'(q[0]));
    end

    // reset mid-stream, with a write request that must lose
    drive(1'b0, 1'b1, 8'h21);
    drive(1'b0, 1'b1, 8'h22);
    bus.wr_i     = 1'b1;
    bus.w_data_i = 8'h99;
    do_reset();
    bus.wr_i = 1'b0;
    q.delete();
    check("mrst_empty", 32'(bus.empty_o), 1);
    check("mrst_full", 32'(bus.full_o), 0);
    check_cnt("mrst_count", 0);
    drive(1'b0, 1'b1, 8'h11);
    check("mrst_head", 32'(bus.r_data_o), 32'h11);
    check("mrst_empty2", 32'(bus.empty_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
